fifo_prio_arbiter: RTL and testbench
====================================

// Module: fifo_prio_arbiter
// PURPOSE
//   Shares the write port of fifo_priority among NREQ requesters. Priority-tagged words (MSB=1) win over
//   untagged ones; ties are resolved round-robin. Per-requester aging promotes starved low-priority sources.
//   The output is a registered valid/ready stage that connects directly to the FIFO input channel.
// PARAMETERS
//   DW      33  word width incl. priority bit at [DW-1]; passed through unmodified
//   NREQ    4   number of requesters (>=2)
//   AGE_MAX 8   losses before a low-priority requester is promoted (>=1)
// PORTS
//   clk           in   1          clock
//   rst           in   1          synchronous, active-high reset
//   req_vld_i     in   NREQ       requester i has a word
//   req_data_i    in   NREQ*DW    word of requester i at [i*DW +: DW]
//   req_rdy_o     out  NREQ       one-hot accept; combinational, from arbitration and output-stage state
//   data_out      out  DW         to fifo_priority data_in
//   vld_o         out  1          to fifo_priority vld_i
//   rdy_i         in   1          from fifo_priority rdy_o
//   grant_id_o    out  $clog2(NREQ)  source index of the word in data_out
//   starve_evt_o  out  1          1-cycle pulse when any age counter reaches AGE_MAX
// BEHAVIOUR
//   Reset: vld_o=0, data_out=0, grant_id_o=0, starve_evt_o=0, all ages=0, rr pointer=NREQ-1 (first search at 0).
//   Load: load = (!vld_o || rdy_i) && |req_vld_i. Output stage states EMPTY (vld_o=0) and FULL (vld_o=1).
//     EMPTY -> FULL on load. FULL -> EMPTY on rdy_i && !load. FULL stays FULL on !rdy_i, or rdy_i && load.
//   Eligible set E = {i : req_vld_i[i] && (req_data_i[i][DW-1] || age[i]==AGE_MAX)}; if E empty, E = all valid.
//   Grant g = first index in E searching from (rr+1) mod NREQ upward with wrap; on load: req_rdy_o[g]=1
//     (exactly one bit), data_out<=req_data_i[g], grant_id_o<=g, vld_o<=1, rr<=g. Only the granted bit is set.
//   Latency: word accepted in cycle N appears on data_out/vld_o in cycle N+1. Throughput 1 word/cycle when rdy_i=1.
//   Hold: vld_o && !rdy_i -> req_rdy_o=0, data_out/grant_id_o stable, ages frozen.
//   Aging (updated only in cycles with load): age[g]<=0; for i!=g with req_vld_i[i] && !req_data_i[i][DW-1]:
//     age[i]<=min(age[i]+1,AGE_MAX). Any requester with req_vld_i=0 clears its age in any cycle.
//     High-priority requesters keep age 0. A promoted requester competes with tagged ones in round-robin.
//   starve_evt_o=1 in the cycle after any age counter transitions to AGE_MAX; 0 otherwise.
//   Empty: no valid requester -> req_rdy_o=0, ages untouched except clears; vld_o drops after a handshake.
//   Simultaneous: rdy_i with new load in the same cycle -> old word retires, new word loads, no bubble.
//   Reset mid-transfer: held word is discarded (vld_o=0 next cycle), no req_rdy_o asserted while rst=1.
//   Width: age counters $clog2(AGE_MAX+1) bits, saturating; rr pointer $clog2(NREQ) bits, wraps NREQ-1->0.
// TESTING
//   1) Reset: hold rst 3 cycles with req_vld_i=4'b1111 -> req_rdy_o=0, vld_o=0, data_out=0 throughout.
//   2) Round-robin: all 4 valid, all MSB=0, rdy_i=1 -> grant_id_o sequence 0,1,2,3,0, one word per cycle.
//   3) Priority: req0 MSB=0, req2 MSB=1 (data 1_0000_00AA), rdy_i=1 -> req2 granted first; data_out=1_0000_00AA.
//   4) Backpressure: vld_o=1, rdy_i=0 for 5 cycles -> data_out stable, req_rdy_o=0; on rdy_i=1 resume next grant.
//   5) Starvation: req1 MSB=0 constant, req0/req3 MSB=1 constant, AGE_MAX=8 -> after 8 losses starve_evt_o
//      pulses once and req1 granted within next 2 grants; its age then returns to 0.
//   6) Handoff into fifo_priority (DEPTH=5): 7 back-to-back words, reader stalled -> 5 accepted, vld_o held
//      with word 6 until the FIFO frees a slot; no word lost or duplicated, order matches grants.

Source files
------------

// File: rtl/fifo_prio_arbiter.sv
// Priority/round-robin arbiter with aging that feeds a registered valid/ready
// output stage sitting directly in front of a FIFO write channel.
module fifo_prio_arbiter #(
    parameter int DW      = 33,
    parameter int NREQ    = 4,
    parameter int AGE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_vld_i,
    input  logic [NREQ*DW-1:0]       req_data_i,
    output logic [NREQ-1:0]          req_rdy_o,
    output logic [DW-1:0]            data_out,
    output logic                     vld_o,
    input  logic                     rdy_i,
    output logic [$clog2(NREQ)-1:0]  grant_id_o,
    output logic                     starve_evt_o
);
    localparam int GW = $clog2(NREQ);
    localparam int AW = $clog2(AGE_MAX + 1);
    localparam logic [AW-1:0] AGE_SAT = AW'(AGE_MAX);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                  state_q, state_d;
    logic [DW-1:0]           data_q;
    logic [GW-1:0]           gid_q;
    logic [GW-1:0]           rr_q;
    logic [NREQ-1:0][AW-1:0] age_q, age_d;
    logic                    starve_q, starve_d;

    logic [NREQ-1:0][DW-1:0] word;
    logic [NREQ-1:0]         msb, hi, elig;
    logic [GW-1:0]           gnt_idx;
    logic                    load;

    // Eligibility (tagged or promoted first) and round-robin search after rr_q
    always_comb begin
        int           idx;
        logic [GW-1:0] idx_w;
        logic         found;
        idx     = 0;
        idx_w   = '0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            word[i] = req_data_i[i*DW +: DW];
            msb[i]  = word[i][DW-1];
            hi[i]   = req_vld_i[i] && (msb[i] || age_q[i] == AGE_SAT);
        end
        elig = (|hi) ? hi : req_vld_i;
        for (int k = 1; k <= NREQ; k++) begin
            idx   = (int'(rr_q) + k) % NREQ;
            idx_w = GW'(idx);
            if (!found && elig[idx_w]) begin
                found   = 1'b1;
                gnt_idx = idx_w;
            end
        end
    end

    // Accept a word when the output stage is free or draining; never during reset
    always_comb begin
        load      = !rst && (state_q == EMPTY || rdy_i) && (|req_vld_i);
        req_rdy_o = '0;
        if (load) req_rdy_o[gnt_idx] = 1'b1;
    end

    // Output stage FSM: EMPTY fills on load, FULL drains when consumed with no refill
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (load) state_d = FULL;
            FULL:    if (rdy_i && !load) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Aging: losers that are valid and untagged count up (saturating); idle sources clear
    always_comb begin
        starve_d = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            age_d[i] = age_q[i];
            if (!req_vld_i[i]) begin
                age_d[i] = '0;
            end else if (load) begin
                if (GW'(i) == gnt_idx || msb[i]) age_d[i] = '0;
                else if (age_q[i] != AGE_SAT)    age_d[i] = age_q[i] + AW'(1);
            end
            if (age_d[i] == AGE_SAT && age_q[i] != AGE_SAT) starve_d = 1'b1;
        end
    end

    // State, output register, rr pointer and age counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            data_q   <= '0;
            gid_q    <= '0;
            rr_q     <= GW'(NREQ - 1);
            age_q    <= '0;
            starve_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            age_q    <= age_d;
            starve_q <= starve_d;
            if (load) begin
                data_q <= word[gnt_idx];
                gid_q  <= gnt_idx;
                rr_q   <= gnt_idx;
            end
        end
    end

    assign vld_o        = (state_q == FULL);
    assign data_out     = data_q;
    assign grant_id_o   = gid_q;
    assign starve_evt_o = starve_q;

endmodule

// File: tb/tb_fifo_prio_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, all
// compared against a queue/integer reference model of the arbitration rules.
module tb_fifo_prio_arbiter;
    localparam int DW = 33, NREQ = 4, AGE_MAX = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_vld;
    logic [NREQ*DW-1:0]      req_data;
    logic [NREQ-1:0]         req_rdy;
    logic [DW-1:0]           data_out;
    logic                    vld_o;
    logic                    rdy_in;
    logic [1:0]              grant_id;
    logic                    starve_evt;

    int checks = 0;
    int fails  = 0;

    // reference model state
    int            m_age [NREQ];
    int            m_rr;
    logic          m_vld, m_starve;
    logic [DW-1:0] m_data;
    int            m_gid;

    // observations captured before the clock edge of the last step
    logic [NREQ-1:0] obs_rdy;
    logic            obs_vld, obs_starve;
    logic [DW-1:0]   obs_data;

    fifo_prio_arbiter #(.DW(DW), .NREQ(NREQ), .AGE_MAX(AGE_MAX)) dut (
        .clk(clk), .rst(rst), .req_vld_i(req_vld), .req_data_i(req_data),
        .req_rdy_o(req_rdy), .data_out(data_out), .vld_o(vld_o), .rdy_i(rdy_in),
        .grant_id_o(grant_id), .starve_evt_o(starve_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) m_age[i] = 0;
        m_rr = NREQ - 1; m_vld = 0; m_data = '0; m_gid = 0; m_starve = 0;
    endtask

    // Winner by the rules: tagged or fully aged sources form the candidate set
    // (else every valid source), first candidate after the last winner wins.
    function automatic int model_grant(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d);
        int cand[$];
        for (int i = 0; i < NREQ; i++)
            if (v[i] && (d[i*DW+DW-1] || m_age[i] == AGE_MAX)) cand.push_back(i);
        if (cand.size() == 0)
            for (int i = 0; i < NREQ; i++) if (v[i]) cand.push_back(i);
        for (int k = 1; k <= NREQ; k++)
            foreach (cand[j]) if (cand[j] == (m_rr + k) % NREQ) return cand[j];
        return -1;
    endfunction

    // One clock cycle: drive, check against the model, clock, advance the model.
    task automatic step(input logic r, input logic [NREQ-1:0] v,
                        input logic [NREQ*DW-1:0] d, input logic rd);
        logic            ld;
        int              g;
        logic [NREQ-1:0] exp_rdy;
        int              old_age [NREQ];
        @(negedge clk);
        rst = r; req_vld = v; req_data = d; rdy_in = rd;
        #1;
        ld = !r && (!m_vld || rd) && (v != 0);
        g  = ld ? model_grant(v, d) : -1;
        exp_rdy = '0;
        if (ld && g >= 0) exp_rdy[g] = 1'b1;
        chk("req_rdy_o", 64'(req_rdy), 64'(exp_rdy));
        chk("vld_o", 64'(vld_o), 64'(m_vld));
        chk("data_out", 64'(data_out), 64'(m_data));
        chk("grant_id_o", 64'(grant_id), 64'(m_gid));
        chk("starve_evt_o", 64'(starve_evt), 64'(m_starve));
        obs_rdy = req_rdy; obs_vld = vld_o; obs_data = data_out; obs_starve = starve_evt;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            foreach (old_age[i]) old_age[i] = m_age[i];
            if (ld) begin
                m_vld = 1; m_data = d[g*DW +: DW]; m_gid = g; m_rr = g;
                for (int i = 0; i < NREQ; i++)
                    if (i == g || !v[i] || d[i*DW+DW-1]) m_age[i] = 0;
                    else if (m_age[i] < AGE_MAX) m_age[i]++;
            end else begin
                if (m_vld && rd) m_vld = 0;
                for (int i = 0; i < NREQ; i++) if (!v[i]) m_age[i] = 0;
            end
            m_starve = 0;
            for (int i = 0; i < NREQ; i++)
                if (m_age[i] == AGE_MAX && old_age[i] != AGE_MAX) m_starve = 1;
        end
    endtask

    function automatic logic [NREQ*DW-1:0] pack4(input logic [DW-1:0] a, b, c, e);
        return {e, c, b, a};
    endfunction

    initial begin
        logic [NREQ*DW-1:0] d;
        logic [DW-1:0]      fq[$];
        logic [DW-1:0]      w;
        int                 nxt, pulses, seen1;
        logic               rd;

        rst = 1; req_vld = '0; req_data = '0; rdy_in = 0;
        @(posedge clk);
        model_reset();

        // reset held with all requesters valid: nothing accepted, outputs idle
        for (int k = 0; k < 3; k++) begin
            step(1, 4'b1111, '0, 1);
            chk("reset_rdy", 64'(obs_rdy), 64'd0);
            chk("reset_vld", 64'(obs_vld), 64'd0);
        end

        // round-robin among equal untagged requesters
        d = pack4(33'h10, 33'h11, 33'h12, 33'h13);
        for (int k = 0; k < 5; k++) begin
            step(0, 4'b1111, d, 1);
            chk("rr_grant", 64'(obs_rdy), 64'(4'b0001 << (k % 4)));
        end

        // tagged requester beats an untagged one
        step(1, '0, '0, 1);
        d = pack4(33'h0_0000_0055, '0, 33'h1_0000_00AA, '0);
        step(0, 4'b0101, d, 1);
        chk("prio_grant", 64'(obs_rdy), 64'(4'b0100));
        #1 chk("prio_data", 64'(data_out), 64'h1_0000_00AA);

        // backpressure: held word, no accepts, then resume
        d = pack4(33'h21, 33'h22, 33'h23, 33'h24);
        step(0, 4'b1111, d, 1);
        for (int k = 0; k < 5; k++) begin
            step(0, 4'b1111, d, 0);
            chk("bp_rdy", 64'(obs_rdy), 64'd0);
        end
        step(0, 4'b1111, d, 1);
        chk("bp_resume", 64'(obs_rdy != 0), 64'd1);

        // starvation of an untagged source against two tagged ones
        step(1, '0, '0, 1);
        d = pack4(33'h1_0000_0000, 33'h0_0000_0001, '0, 33'h1_0000_0003);
        pulses = 0; seen1 = 0;
        for (int k = 0; k < 14; k++) begin
            step(0, 4'b1011, d, 1);
            if (obs_starve) pulses++;
            if (obs_rdy[1]) seen1++;
        end
        chk("starve_pulses", 64'(pulses), 64'd1);
        chk("starve_granted", 64'(seen1), 64'd1);

        // handoff into a 5-deep FIFO whose reader is stalled
        step(1, '0, '0, 1);
        fq.delete(); nxt = 0;
        for (int k = 0; k < 12; k++) begin
            rd = (fq.size() < 5);
            w = DW'(nxt);
            step(0, (nxt < 7) ? 4'b0001 : 4'b0000, pack4(w, '0, '0, '0), rd);
            if (obs_rdy[0]) nxt++;
            if (obs_vld && rd) fq.push_back(obs_data);
        end
        chk("fifo_count", 64'(fq.size()), 64'd5);
        chk("fifo_hold_vld", 64'(vld_o), 64'd1);
        chk("fifo_hold_data", 64'(data_out), 64'd5);
        w = fq.pop_front();
        chk("fifo_first", 64'(w), 64'd0);
        for (int k = 0; k < 6; k++) begin
            rd = (fq.size() < 5);
            w = DW'(nxt);
            step(0, (nxt < 7) ? 4'b0001 : 4'b0000, pack4(w, '0, '0, '0), rd);
            if (obs_rdy[0]) nxt++;
            if (obs_vld && rd) fq.push_back(obs_data);
            if (fq.size() == 5 && k > 2) begin
                w = fq.pop_front();
            end
        end
        chk("fifo_words_taken", 64'(nxt), 64'd7);
        for (int i = 1; i < fq.size(); i++)
            chk("fifo_order", 64'(fq[i] > fq[i-1]), 64'd1);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [NREQ-1:0]    v;
            logic [NREQ*DW-1:0] rdat;
            v = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++)
                rdat[i*DW +: DW] = {($urandom_range(0, 3) == 0), 32'($urandom)};
            step(($urandom_range(0, 60) == 0), v, rdat, ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
